// File: rtl/lift_motor_drive.sv
// Hoist motor drive for an N-floor shaft: one target-floor command at a time,
// floor-sensor position tracking, PWM soft-start/soft-stop and reversal dead time.
module lift_motor_drive #(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = 3,
    parameter int SPD_W      = 3,
    parameter int RAMP_DIV   = 2,
    parameter int DEADTIME   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [FLOOR_W-1:0] cmd_floor,
    output logic               cmd_ready,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               floor_arrive,
    input  logic               estop,
    input  logic               fault_clr,
    output logic               motor_onoff,
    output logic               motor_dir,
    output logic               motor_pwm,
    output logic               busy,
    output logic               done,
    output logic               cmd_err,
    output logic               fault
);

    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [SPD_W-1:0]   SPD_MAX   = '1;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEADTIME - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAD,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] pos_q, pos_d;
    logic [FLOOR_W-1:0] target_q, target_d;
    logic [SPD_W-1:0]   speed_q, speed_d;
    logic [SPD_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [RAMP_W-1:0]  ramp_cnt_q, ramp_cnt_d;
    logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
    logic               last_dir_q, last_dir_d;
    logic               motor_dir_q, motor_dir_d;
    logic               motor_onoff_q, motor_onoff_d;
    logic               motor_pwm_q, motor_pwm_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cmd_err_q, cmd_err_d;
    logic               fault_q, fault_d;

    logic               ramp_step;
    logic               at_limit;
    logic [FLOOR_W-1:0] moved_pos;
    logic               cmd_in_range;
    logic               req_up;
    logic               arrive_hit;

    assign ramp_step    = (ramp_cnt_q == RAMP_LAST);
    assign at_limit     = motor_dir_q ? (pos_q == TOP_FLOOR) : (pos_q == '0);
    assign moved_pos    = motor_dir_q ? (pos_q + 1'b1) : (pos_q - 1'b1);
    assign cmd_in_range = (int'(cmd_floor) < NUM_FLOORS);
    assign req_up       = (cmd_floor > cur_floor);
    assign arrive_hit   = floor_arrive && !at_limit && (moved_pos == target_q);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        target_d    = target_q;
        speed_d     = speed_q;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        ramp_cnt_d  = ramp_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        last_dir_d  = last_dir_q;
        motor_dir_d = motor_dir_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        fault_d     = fault_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    pos_d    = cur_floor;
                    target_d = cmd_floor;
                    if (!cmd_in_range) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_floor == cur_floor) begin
                        done_d = 1'b1;
                    end else begin
                        motor_dir_d = req_up;
                        last_dir_d  = req_up;
                        speed_d     = '0;
                        ramp_cnt_d  = '0;
                        dead_cnt_d  = '0;
                        state_d     = (req_up != last_dir_q) ? S_DEAD : S_ACCEL;
                    end
                end
            end
            S_DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    ramp_cnt_d = '0;
                    state_d    = S_ACCEL;
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                // Running past the end of the shaft means the position model is broken.
                if (floor_arrive && at_limit) begin
                    speed_d = '0;
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    if (floor_arrive) begin
                        pos_d = moved_pos;
                    end
                    if (arrive_hit && state_q != S_DECEL) begin
                        ramp_cnt_d = '0;
                        state_d    = S_DECEL;
                    end else if (state_q == S_ACCEL) begin
                        if (ramp_step) begin
                            ramp_cnt_d = '0;
                            speed_d    = speed_q + 1'b1;
                            if (speed_q == SPD_MAX - 1'b1) begin
                                state_d = S_CRUISE;
                            end
                        end else begin
                            ramp_cnt_d = ramp_cnt_q + 1'b1;
                        end
                    end else if (state_q == S_DECEL) begin
                        if (speed_q == '0 || (ramp_step && speed_q == 1'b1)) begin
                            speed_d = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else if (ramp_step) begin
                            ramp_cnt_d = '0;
                            speed_d    = speed_q - 1'b1;
                        end else begin
                            ramp_cnt_d = ramp_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_FAULT: begin
                speed_d = '0;
                if (fault_clr && !estop) begin
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Emergency stop overrides every other decision made this cycle.
        if (estop) begin
            speed_d   = '0;
            fault_d   = 1'b1;
            done_d    = 1'b0;
            cmd_err_d = 1'b0;
            state_d   = S_FAULT;
        end

        motor_onoff_d = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);
        motor_pwm_d   = motor_onoff_d && (pwm_cnt_d < speed_d);
        cmd_ready_d   = (state_d == S_IDLE) && !fault_d;
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pos_q         <= '0;
            target_q      <= '0;
            speed_q       <= '0;
            pwm_cnt_q     <= '0;
            ramp_cnt_q    <= '0;
            dead_cnt_q    <= '0;
            last_dir_q    <= 1'b0;
            motor_dir_q   <= 1'b0;
            motor_onoff_q <= 1'b0;
            motor_pwm_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            target_q      <= target_d;
            speed_q       <= speed_d;
            pwm_cnt_q     <= pwm_cnt_d;
            ramp_cnt_q    <= ramp_cnt_d;
            dead_cnt_q    <= dead_cnt_d;
            last_dir_q    <= last_dir_d;
            motor_dir_q   <= motor_dir_d;
            motor_onoff_q <= motor_onoff_d;
            motor_pwm_q   <= motor_pwm_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cmd_err_q     <= cmd_err_d;
            fault_q       <= fault_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign motor_onoff = motor_onoff_q;
    assign motor_dir   = motor_dir_q;
    assign motor_pwm   = motor_pwm_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_err     = cmd_err_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_lift_motor_drive.sv
// Directed bench for lift_motor_drive: a cycle-block vector table for the
// travel scenarios plus hand sequences for reset, PWM duty and peak speed.
module tb_lift_motor_drive;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_floor = '0;
    logic [2:0] cur_floor = '0;
    logic       floor_arrive = 1'b0;
    logic       estop = 1'b0;
    logic       fault_clr = 1'b0;
    logic       cmd_ready, motor_onoff, motor_dir, motor_pwm;
    logic       busy, done, cmd_err, fault;

    always #5 clk = ~clk;

    lift_motor_drive dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_floor    (cmd_floor),
        .cmd_ready    (cmd_ready),
        .cur_floor    (cur_floor),
        .floor_arrive (floor_arrive),
        .estop        (estop),
        .fault_clr    (fault_clr),
        .motor_onoff  (motor_onoff),
        .motor_dir    (motor_dir),
        .motor_pwm    (motor_pwm),
        .busy         (busy),
        .done         (done),
        .cmd_err      (cmd_err),
        .fault        (fault)
    );

    // exp = {onoff, dir, busy, done, err, fault, ready}; n = edges to hold inputs
    typedef struct {
        logic       cv;
        logic [2:0] cf;
        logic [2:0] cur;
        logic       arr;
        logic       es;
        logic       clr;
        int         n;
        logic [6:0] exp;
        logic       chk_dir;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vecs [NVEC];

    int total = 0;
    int bad   = 0;

    logic [7:0] win;
    int         win_max;
    bit         mon_en = 1'b0;

    // Sliding 8-cycle window of PWM highs, used to bound the peak speed.
    always @(negedge clk) begin
        if (mon_en) begin
            win = {win[6:0], motor_pwm};
            if ($countones(win) > win_max) win_max = $countones(win);
        end
    end

    function automatic vec_t mk(logic cv, int cf, int cur, logic arr, logic es,
                                logic clr, int n, logic [6:0] exp, logic cd);
        vec_t v;
        v.cv = cv; v.cf = 3'(cf); v.cur = 3'(cur); v.arr = arr; v.es = es;
        v.clr = clr; v.n = n; v.exp = exp; v.chk_dir = cd;
        return v;
    endfunction

    task automatic checkValue(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        logic [7:0] act;
        logic [7:0] req;
        act = {motor_onoff, v.chk_dir ? motor_dir : 1'b0, busy, done, cmd_err, fault,
               cmd_ready, v.exp[6] ? 1'b0 : motor_pwm};
        req = {v.exp[6], v.chk_dir ? v.exp[5] : 1'b0, v.exp[4:0], 1'b0};
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: outputs {onoff,dir,busy,done,err,fault,ready,pwm} got %b, expected %b",
                     name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_valid    = v.cv;
        cmd_floor    = v.cf;
        cur_floor    = v.cur;
        floor_arrive = v.arr;
        estop        = v.es;
        fault_clr    = v.clr;
        repeat (v.n) @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        cmd_valid = 1'b0; floor_arrive = 1'b0; estop = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic runTable(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d", i), vecs[i]);
            setIdle();
        end
    endtask

    initial begin
        int cnt;

        // up run 0->3 with reversal dead time from reset direction
        vecs[0]  = mk(1, 3, 0, 0, 0, 0, 1,  7'b0110000, 1);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 3,  7'b0110000, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1,  7'b1110000, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 14, 7'b1110000, 1);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0, 1,  7'b1110000, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1,  7'b1110000, 1);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0, 1,  7'b1110000, 1);
        vecs[7]  = mk(0, 0, 0, 1, 0, 0, 1,  7'b1110000, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 13, 7'b1110000, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1,  7'b0101001, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1,  7'b0100001, 1);
        // same-direction 3->4, no dead time, arrival before first step
        vecs[11] = mk(1, 4, 3, 0, 0, 0, 1,  7'b1110000, 1);
        vecs[12] = mk(0, 0, 0, 1, 0, 0, 1,  7'b1110000, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 1,  7'b0101001, 1);
        // reversal 4->3, arrival at speed 2
        vecs[14] = mk(1, 3, 4, 0, 0, 0, 1,  7'b0010000, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 3,  7'b0010000, 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1,  7'b1010000, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 4,  7'b1010000, 1);
        vecs[18] = mk(0, 0, 0, 1, 0, 0, 1,  7'b1010000, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 3,  7'b1010000, 1);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 1,  7'b0001001, 1);
        // out-of-range and same-floor commands
        vecs[21] = mk(1, 6, 2, 0, 0, 0, 1,  7'b0000101, 1);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 1,  7'b0000001, 1);
        vecs[23] = mk(1, 2, 2, 0, 0, 0, 1,  7'b0001001, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 1,  7'b0000001, 1);
        // up 2->4 into cruise
        vecs[25] = mk(1, 4, 2, 0, 0, 0, 1,  7'b0110000, 1);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 18, 7'b1110000, 1);
        // estop in cruise, clear attempts, estop in idle
        vecs[27] = mk(0, 0, 0, 0, 1, 0, 1,  7'b0010010, 0);
        vecs[28] = mk(0, 0, 0, 0, 1, 1, 1,  7'b0010010, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 1, 1,  7'b0000001, 0);
        vecs[30] = mk(0, 0, 0, 0, 1, 0, 1,  7'b0010010, 0);
        vecs[31] = mk(0, 0, 0, 0, 0, 1, 1,  7'b0000001, 0);
        // down 1->0 then one arrival too many
        vecs[32] = mk(1, 0, 1, 0, 0, 0, 1,  7'b0010000, 1);
        vecs[33] = mk(0, 0, 0, 0, 0, 0, 4,  7'b1010000, 1);
        vecs[34] = mk(0, 0, 0, 1, 0, 0, 1,  7'b1010000, 1);
        vecs[35] = mk(0, 0, 0, 1, 0, 0, 1,  7'b0010010, 0);
        vecs[36] = mk(0, 0, 0, 0, 0, 1, 1,  7'b0000001, 0);

        #12;
        checkValue("reset_outputs",
                   int'({cmd_ready, motor_onoff, motor_dir, motor_pwm, busy, done, cmd_err, fault}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkValue("ready_after_reset", int'({cmd_ready, busy}), 2);

        runTable(0, 13);
        win = '0; win_max = 0; mon_en = 1'b1;
        runTable(14, 20);
        mon_en = 1'b0;
        if (win_max > 2) checkValue("reversal_peak_pwm_per8", win_max, 2);
        else checkValue("reversal_peak_pwm_per8", 2, 2 - 0 * win_max);

        runTable(21, 26);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            cnt += int'(motor_pwm);
        end
        checkValue("cruise_pwm_duty_16", cnt, 14);

        runTable(27, 36);

        // reset while accelerating: outputs must drop without a clock edge
        cmd_valid = 1'b1; cmd_floor = 3'd1; cur_floor = 3'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkValue("accel_before_reset", int'({motor_onoff, busy}), 3);
        #2 rst = 1'b0;
        #1;
        checkValue("async_reset_outputs",
                   int'({cmd_ready, motor_onoff, motor_dir, motor_pwm, busy, done, cmd_err, fault}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkValue("ready_after_rereset", int'({cmd_ready, busy, motor_onoff}), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lift_motor_drive.md
Name: lift_motor_drive

Overview:
- Parametrised successor of the two-floor motor on/off controller: drives the elevator hoist motor for an N-floor shaft.
- Accepts one target-floor command at a time and tracks cabin position from floor-sensor pulses.
- Generates soft-start/soft-stop PWM speed ramps and inserts motor-off dead time on direction reversal.
- Sits between the floor-request scheduler (above) and the motor driver pins (below).

Parameters:
- NUM_FLOORS, 5, number of floors; valid floor indices are 0..NUM_FLOORS-1.
- FLOOR_W, 3, width of the floor index; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- SPD_W, 3, width of the speed level and PWM counter; SPD_MAX = 2^SPD_W-1.
- RAMP_DIV, 2, clock cycles per ±1 speed step during a ramp (>=1).
- DEADTIME, 4, motor-off cycles inserted before a direction reversal (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  target-floor request valid.
- cmd_floor  in  FLOOR_W  requested floor.
- cmd_ready  out  1  high only in IDLE with fault clear.
- cur_floor  in  FLOOR_W  floor the cabin is parked at; sampled on command accept.
- floor_arrive  in  1  one-cycle pulse, cabin passed or reached a floor sensor.
- estop  in  1  emergency stop, level-sensitive.
- fault_clr  in  1  clears a latched fault.
- motor_onoff  out  1  motor enable.
- motor_dir  out  1  1 = up, 0 = down.
- motor_pwm  out  1  PWM drive.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, travel complete.
- cmd_err  out  1  one-cycle pulse, out-of-range command rejected.
- fault  out  1  sticky fault flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; pos=0, target=0, speed=0, last_dir=0, pwm_cnt=0, dead_cnt=0; all outputs 0 except cmd_ready=0. cmd_ready rises the first cycle after reset release.
- All outputs are registered.
- A command is accepted on a clock edge with cmd_valid & cmd_ready. On accept, pos<=cur_floor and target<=cmd_floor.
  - If cmd_floor >= NUM_FLOORS: cmd_err pulses the next cycle; state stays IDLE.
  - If cmd_floor == cur_floor: done pulses the next cycle; motor stays off.
  - Otherwise dir = (cmd_floor > cur_floor). If dir != last_dir, go to DEAD; else go to ACCEL.
  - In both cases motor_dir<=dir and last_dir<=dir.
- DEAD: motor_onoff=0 for DEADTIME cycles, then ACCEL.
- ACCEL: motor_onoff=1. speed increments by 1 every RAMP_DIV cycles, starting from 0; the first step lands RAMP_DIV cycles after entry. At SPD_MAX the state moves to CRUISE.
- CRUISE: speed holds at SPD_MAX.
- floor_arrive while in ACCEL, CRUISE or DECEL: pos += 1 if up, pos -= 1 if down.
  - If the updated pos == target, go to DECEL, or stay in DECEL, starting from the current speed.
  - If the update would go below 0 or above NUM_FLOORS-1, go to FAULT.
- floor_arrive in IDLE or DEAD is ignored.
- DECEL: speed decrements every RAMP_DIV cycles. When speed reaches 0: motor_onoff<=0, done pulses once, state returns to IDLE. motor_dir holds its value.
- PWM: pwm_cnt is a free-running SPD_W-bit counter that wraps at SPD_MAX. motor_pwm = motor_onoff & (pwm_cnt < speed). At speed=0 the output is always 0; at SPD_MAX it is high for SPD_MAX of every 2^SPD_W cycles.
- estop=1 has highest priority in any state.
  - Next edge: speed=0, motor_onoff=0, motor_pwm=0, fault=1, state=FAULT.
  - An estop during IDLE also faults.
- FAULT: outputs off and cmd_ready=0. The block leaves FAULT for IDLE on fault_clr=1 with estop=0; fault clears on the same edge. pos and last_dir are retained.
- Simultaneous events:
  - estop beats floor_arrive and ramp steps.
  - A floor_arrive that reaches target in the same cycle as an ACCEL step: DECEL is entered and the step is discarded.
- A reset mid-travel immediately drops motor_onoff and motor_pwm asynchronously.

Test Plan:
- Up run: cur_floor=0, cmd_floor=3, defaults, last_dir=0 → DEAD for 4 cycles. Then speed ramps 1..7 every 2 cycles to CRUISE. Three floor_arrive pulses → DECEL 7..0, done=1 for one cycle, motor_dir=1 throughout.
- Same-direction repeat: after the up run, command 3→4 → no DEAD; motor_onoff=1 the cycle after accept.
- Reversal plus short hop: command 4→3, with floor_arrive issued during ACCEL at speed=2 → DEAD 4 cycles, then DECEL 2→0 and done. Peak speed never exceeds 2.
- Errors: cmd_floor=6 → cmd_err pulse, busy stays 0. cmd_floor==cur_floor=2 → done pulse, motor_onoff stays 0.
- estop in CRUISE → motor_onoff/motor_pwm=0 on the next edge, fault=1, cmd_ready=0. fault_clr with estop=1 → no change. fault_clr with estop=0 → IDLE, cmd_ready=1.
- PWM duty: hold CRUISE with SPD_W=3 → motor_pwm high exactly 7 of every 8 cycles.
- Position overflow: a down command with an extra floor_arrive below floor 0 → FAULT.
- Reset asserted mid-ACCEL → all outputs 0 immediately.
